// File: rtl/banked_mem_arbiter.sv
// Multi-bank shared-memory arbiter: one round-robin grant per bank per cycle, one-cycle latency.
// Optional per-core stall counters are enabled with `define BANKED_MEM_ARB_STALL_CNT_EN.
module banked_mem_arbiter #(
  parameter int unsigned NUM_CORES   = 4,
  parameter int unsigned BANK_SEL_W  = 2,
  parameter int unsigned WORD_ADDR_W = 6,
  parameter int unsigned DATA_W      = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [2*NUM_CORES-1:0]                        enable,
  input  logic [NUM_CORES*(BANK_SEL_W+WORD_ADDR_W)-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0]                   wr_data,
  output logic [NUM_CORES*DATA_W-1:0]                   rd_data,
  output logic [NUM_CORES-1:0]                          ready
`ifdef BANKED_MEM_ARB_STALL_CNT_EN
  ,
  output logic [NUM_CORES*16-1:0]                       stall_cnt
`endif
);

  localparam int unsigned NUM_BANKS = 2 ** BANK_SEL_W;
  localparam int unsigned ADDR_W    = BANK_SEL_W + WORD_ADDR_W;
  localparam int unsigned DEPTH     = 2 ** WORD_ADDR_W;
  localparam int unsigned CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0]        eligible;
  logic [NUM_CORES-1:0]        is_write;
  logic [NUM_CORES-1:0]        grant;
  logic [BANK_SEL_W-1:0]       bank_sel   [NUM_CORES];
  logic [WORD_ADDR_W-1:0]      word_addr  [NUM_CORES];

  logic [NUM_BANKS-1:0]        bank_gnt;
  logic [CORE_W-1:0]           bank_gnt_id [NUM_BANKS];
  logic [NUM_BANKS-1:0]        bank_we;
  logic [WORD_ADDR_W-1:0]      bank_waddr  [NUM_BANKS];
  logic [DATA_W-1:0]           bank_wdata  [NUM_BANKS];
  logic [DATA_W-1:0]           bank_rdata  [NUM_BANKS];

  logic [CORE_W-1:0]           ptr_q       [NUM_BANKS];
  // Last cycle's grants: doubles as the ready pulse and the eligibility mask.
  logic [NUM_CORES-1:0]        grant_q;
  logic [NUM_CORES*DATA_W-1:0] rd_data_d, rd_data_q;
  logic [DATA_W-1:0]           mem_q       [NUM_BANKS][DEPTH];

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      eligible[c]  = (enable[2*c +: 2] != 2'b00) && !grant_q[c];
      is_write[c]  = enable[2*c+1];
      bank_sel[c]  = addr[c*ADDR_W+WORD_ADDR_W +: BANK_SEL_W];
      word_addr[c] = addr[c*ADDR_W +: WORD_ADDR_W];
    end
  end

  // Per-bank round-robin search starting just above the bank's last winner.
  always_comb begin
    logic [CORE_W-1:0] idx;
    idx = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_gnt[b]    = 1'b0;
      bank_gnt_id[b] = '0;
      for (int k = 1; k <= NUM_CORES; k++) begin
        idx = CORE_W'((int'(ptr_q[b]) + k) % NUM_CORES);
        if (!bank_gnt[b] && eligible[idx] && (bank_sel[idx] == BANK_SEL_W'(b))) begin
          bank_gnt[b]    = 1'b1;
          bank_gnt_id[b] = idx;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      grant[c] = eligible[c] && bank_gnt[bank_sel[c]] &&
                 (bank_gnt_id[bank_sel[c]] == CORE_W'(c));
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_we[b]    = bank_gnt[b] && is_write[bank_gnt_id[b]];
      bank_waddr[b] = word_addr[bank_gnt_id[b]];
      bank_wdata[b] = wr_data[int'(bank_gnt_id[b])*DATA_W +: DATA_W];
      bank_rdata[b] = mem_q[b][bank_waddr[b]];
    end
  end

  always_comb begin
    rd_data_d = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (grant[c] && !is_write[c]) begin
        rd_data_d[c*DATA_W +: DATA_W] = bank_rdata[bank_sel[c]];
      end
    end
  end

  // Bank storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!reset && bank_we[b]) begin
        mem_q[b][bank_waddr[b]] <= bank_wdata[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        ptr_q[b] <= CORE_W'(NUM_CORES - 1);
      end
      grant_q   <= '0;
      rd_data_q <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (bank_gnt[b]) begin
          ptr_q[b] <= bank_gnt_id[b];
        end
      end
      grant_q   <= grant;
      rd_data_q <= rd_data_d;
    end
  end

  assign ready   = grant_q;
  assign rd_data = rd_data_q;

`ifdef BANKED_MEM_ARB_STALL_CNT_EN
  logic [15:0] stall_q [NUM_CORES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        stall_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (eligible[c] && !grant[c] && (stall_q[c] != 16'hFFFF)) begin
          stall_q[c] <= stall_q[c] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      stall_cnt[c*16 +: 16] = stall_q[c];
    end
  end
`endif

endmodule

// File: tb/tb_banked_mem_arbiter.sv
// Scoreboard bench for banked_mem_arbiter: directed scenarios plus random traffic against
// a behavioural model of the memory, per-bank round-robin and one-cycle response.
module tb_banked_mem_arbiter;

  localparam int NC = 4;
  localparam int BS = 2;
  localparam int WA = 6;
  localparam int DW = 8;
  localparam int NB = 4;
  localparam int AW = BS + WA;

  logic             clk = 1'b0;
  logic             reset;
  logic [2*NC-1:0]  enable;
  logic [NC*AW-1:0] addr;
  logic [NC*DW-1:0] wr_data;
  logic [NC*DW-1:0] rd_data;
  logic [NC-1:0]    ready;
`ifdef BANKED_MEM_ARB_STALL_CNT_EN
  logic [NC*16-1:0] stall_cnt;
`endif

  banked_mem_arbiter #(
    .NUM_CORES  (NC),
    .BANK_SEL_W (BS),
    .WORD_ADDR_W(WA),
    .DATA_W     (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .ready    (ready)
`ifdef BANKED_MEM_ARB_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NC-1:0]    rdy;
    logic [NC*DW-1:0] rd;
`ifdef BANKED_MEM_ARB_STALL_CNT_EN
    logic [NC*16-1:0] st;
`endif
  } exp_t;

  exp_t exp_q[$];
  int   obs_q[$];
  bit   log_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Core-side request state (what each core is presenting)
  logic [1:0]    c_op   [NC];
  logic [AW-1:0] c_addr [NC];
  logic [DW-1:0] c_wd   [NC];

  // Reference model state
  int            m_ptr  [NB];
  bit            m_last [NC];
  int            m_stall[NC];
  logic [DW-1:0] m_mem  [int];

  // Monitor: compare every presented output cycle against the scoreboard head.
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (ready !== mon_e.rdy) begin
        n_fail++;
        $display("FAIL ready @%0t: got %b required %b", $time, ready, mon_e.rdy);
      end
      n_checks++;
      if (rd_data !== mon_e.rd) begin
        n_fail++;
        $display("FAIL rd_data @%0t: got %h required %h", $time, rd_data, mon_e.rd);
      end
`ifdef BANKED_MEM_ARB_STALL_CNT_EN
      n_checks++;
      if (stall_cnt !== mon_e.st) begin
        n_fail++;
        $display("FAIL stall_cnt @%0t: got %h required %h", $time, stall_cnt, mon_e.st);
      end
`endif
      if (log_en) begin
        for (int c = 0; c < NC; c++) if (ready[c] === 1'b1) obs_q.push_back(c);
      end
    end
  end

  // Present the current requests for one cycle, predict the response, advance the model.
  task automatic step(input bit rst);
    exp_t e;
    bit   g[NC];
    for (int c = 0; c < NC; c++) begin
      enable[2*c +: 2]   = c_op[c];
      addr[c*AW +: AW]   = c_addr[c];
      wr_data[c*DW +: DW] = c_wd[c];
      g[c] = 1'b0;
    end
    reset = rst;
    e.rdy = '0;
    e.rd  = '0;
    if (rst) begin
      for (int b = 0; b < NB; b++) m_ptr[b] = NC - 1;
      for (int c = 0; c < NC; c++) begin
        m_last[c]  = 1'b0;
        m_stall[c] = 0;
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        bit found = 1'b0;
        for (int k = 1; k <= NC; k++) begin
          int c = (m_ptr[b] + k) % NC;
          if (!found && c_op[c] != 2'b00 && !m_last[c] && int'(c_addr[c][AW-1 -: BS]) == b) begin
            found = 1'b1;
            g[c] = 1'b1;
          end
        end
      end
      for (int c = 0; c < NC; c++) begin
        if (c_op[c] != 2'b00 && !m_last[c] && !g[c] && m_stall[c] < 65535) m_stall[c]++;
        if (g[c]) begin
          m_ptr[int'(c_addr[c][AW-1 -: BS])] = c;
          e.rdy[c] = 1'b1;
          if (c_op[c][1]) m_mem[int'(c_addr[c])] = c_wd[c];
          else e.rd[c*DW +: DW] = m_mem.exists(int'(c_addr[c])) ? m_mem[int'(c_addr[c])] : 'x;
        end
      end
      for (int c = 0; c < NC; c++) m_last[c] = g[c];
    end
`ifdef BANKED_MEM_ARB_STALL_CNT_EN
    for (int c = 0; c < NC; c++) e.st[c*16 +: 16] = 16'(m_stall[c]);
`endif
    exp_q.push_back(e);
    @(negedge clk);
    // Cores granted in the cycle just ended see ready now and release their request.
    for (int c = 0; c < NC; c++) begin
      if (rst || m_last[c]) c_op[c] = 2'b00;
    end
  endtask

  function automatic bit any_busy();
    for (int c = 0; c < NC; c++) if (c_op[c] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_until_idle(input int limit);
    int n = 0;
    while (any_busy() && n < limit) begin
      step(1'b0);
      n++;
    end
    n_checks++;
    if (any_busy()) begin
      n_fail++;
      $display("FAIL drain_timeout: requests still pending after %0d cycles, required 0", n);
      for (int c = 0; c < NC; c++) c_op[c] = 2'b00;
    end
  endtask

  task automatic req(input int c, input logic [1:0] op, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    c_op[c]   = op;
    c_addr[c] = a;
    c_wd[c]   = d;
  endtask

  task automatic check_obs(input string name, input int idx, input int want);
    n_checks++;
    if (obs_q.size() <= idx) begin
      n_fail++;
      $display("FAIL %s: only %0d grants seen, required entry %0d = core %0d",
               name, obs_q.size(), idx, want);
    end else if (obs_q[idx] != want) begin
      n_fail++;
      $display("FAIL %s: grant %0d went to core %0d, required core %0d",
               name, idx, obs_q[idx], want);
    end
  endtask

  task automatic rand_issue();
    for (int c = 0; c < NC; c++) begin
      if (c_op[c] == 2'b00 && $urandom_range(0, 3) != 0) begin
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, NB - 1) * 64 + $urandom_range(0, 3));
        if (m_mem.exists(int'(a)) && $urandom_range(0, 1) == 1) req(c, 2'b01, a, DW'($urandom));
        else req(c, 2'($urandom_range(2, 3)), a, DW'($urandom));
      end
    end
  endtask

  initial begin
    for (int c = 0; c < NC; c++) req(c, 2'b00, '0, '0);
    reset   = 1'b1;
    enable  = '0;
    addr    = '0;
    wr_data = '0;
    @(negedge clk);
    step(1'b1);
    step(1'b1);

    // Single-core write then read back
    req(0, 2'b10, 8'h43, 8'hA5);
    run_until_idle(10);
    req(0, 2'b01, 8'h43, 8'h00);
    run_until_idle(10);

    // Parallel banks: preload word 0 of each bank, then read all four at once
    for (int c = 0; c < NC; c++) req(c, 2'b10, AW'(c * 64), DW'($urandom));
    run_until_idle(10);
    for (int c = 0; c < NC; c++) req(c, 2'b01, AW'(c * 64), 8'h00);
    run_until_idle(10);

    // Contention on bank 2 straight after reset: grants rotate 0,1,2,3
    step(1'b1);
    obs_q.delete();
    log_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < NC; c++) if (c_op[c] == 2'b00) req(c, 2'b01, 8'h80, 8'h00);
      step(1'b0);
    end
    run_until_idle(20);
    step(1'b0);
    log_en = 1'b0;
    for (int i = 0; i < 8; i++) check_obs("rr_order", i, i % NC);

    // Pointer independence: bank 0 traffic must not move bank 1's pointer
    step(1'b1);
    req(0, 2'b01, 8'h00, 8'h00);
    req(1, 2'b01, 8'h00, 8'h00);
    run_until_idle(10);
    obs_q.delete();
    log_en = 1'b1;
    req(2, 2'b01, 8'h40, 8'h00);
    req(3, 2'b01, 8'h40, 8'h00);
    run_until_idle(10);
    step(1'b0);
    log_en = 1'b0;
    check_obs("bank1_first", 0, 2);
    check_obs("bank1_second", 1, 3);

    // Reset during the grant cycle of a write: write is lost, core 0 wins afterwards
    req(1, 2'b10, 8'h45, 8'h11);
    run_until_idle(10);
    req(1, 2'b10, 8'h45, 8'h3C);
    step(1'b1);
    obs_q.delete();
    log_en = 1'b1;
    req(0, 2'b01, 8'h45, 8'h00);
    req(1, 2'b01, 8'h45, 8'h00);
    run_until_idle(10);
    step(1'b0);
    log_en = 1'b0;
    check_obs("post_reset_first", 0, 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rand_issue();
      step($urandom_range(0, 499) == 0);
    end
    run_until_idle(50);

    step(1'b0);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
